// File: rtl/dtc.sv
// dtc: digital-to-time converter, emits one pulse of dtc_in clock periods per trig rising edge
module dtc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] dtc_in,
   input  logic             trig,
   output logic             dtc_out
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             trig_q, out_q, out_d, start_evt, load;
   assign start_evt = trig & ~trig_q;
   assign load      = (state_q == IDLE) & start_evt & (dtc_in != '0);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         trig_q  <= 1'b0;
         out_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         trig_q  <= trig;
         out_q   <= out_d;
      end
   end
   // code is latched only from IDLE, so BUSY ignores both trig and dtc_in
   always_comb begin
      state_d = (state_q == IDLE) ? (load ? BUSY : IDLE) : ((cnt_q == WIDTH'(1)) ? IDLE : BUSY);
      cnt_d   = load ? dtc_in : ((state_q == BUSY) ? cnt_q - WIDTH'(1) : cnt_q);
   end
   always_comb begin
      out_d = (state_d == BUSY);
   end
   assign dtc_out = out_q;
endmodule

// File: tb/tb_dtc.sv
// tb_dtc: directed checks of pulse width, boundary codes, retrigger, reset abort and back-to-back pulses
module tb_dtc;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] dtc_in = '0;
   logic       trig = 1'b0;
   logic       dtc_out;
   int         n_chk = 0, n_fail = 0;
   int         run = 0, low = 0, last_w = 0, last_gap = 0, npulse = 0, n0;

   dtc #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .dtc_in(dtc_in), .trig(trig), .dtc_out(dtc_out));

   always #5 clk = ~clk;

   // pulse monitor: widths and gaps measured in clock periods, sampled on falling edges
   always @(negedge clk) begin
      if (dtc_out) begin
         if (run == 0) begin
            last_gap = low;
            low = 0;
         end
         run++;
      end else begin
         if (run > 0) begin
            last_w = run;
            npulse++;
            run = 0;
         end
         low++;
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic fire(input int code);
      step();
      dtc_in = 8'(code);
      trig = 1'b1;
      step();
      trig = 1'b0;
      check("rise", int'(dtc_out), int'(code != 0));
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400 && dtc_out; i++) step();
      check("timeout", int'(dtc_out), 0);
   endtask

   task automatic pulse_test(input int code, input int exp);
      n0 = npulse;
      fire(code);
      wait_done();
      check($sformatf("width_%0d", code), last_w, exp);
      check($sformatf("count_%0d", code), npulse - n0, 1);
   endtask

   initial begin
      #1 rst = 1'b0;
      #1 check("reset_out", int'(dtc_out), 0);
      repeat (2) step();
      rst = 1'b1;
      repeat (10) step();
      check("idle_pulses", npulse, 0);
      check("idle_out", int'(dtc_out), 0);

      pulse_test(5, 5);
      pulse_test(50, 50);
      pulse_test(255, 255);
      pulse_test(1, 1);

      n0 = npulse;
      fire(0);
      repeat (12) step();
      check("zero_pulses", npulse - n0, 0);
      check("zero_out", int'(dtc_out), 0);
      pulse_test(3, 3);

      n0 = npulse;
      fire(20);
      repeat (4) step();
      dtc_in = 8'd2;
      trig = 1'b1;
      step();
      trig = 1'b0;
      wait_done();
      check("retrig_width", last_w, 20);
      check("retrig_count", npulse - n0, 1);

      n0 = npulse;
      step();
      dtc_in = 8'd4;
      trig = 1'b1;
      repeat (30) step();
      trig = 1'b0;
      step();
      check("held_width", last_w, 4);
      check("held_count", npulse - n0, 1);

      fire(100);
      repeat (9) step();
      check("pre_abort_out", int'(dtc_out), 1);
      rst = 1'b0;
      #1 check("abort_async", int'(dtc_out), 0);
      step();
      rst = 1'b1;
      n0 = npulse;
      repeat (10) step();
      check("abort_no_resume", npulse - n0, 0);
      check("abort_out", int'(dtc_out), 0);
      pulse_test(7, 7);

      n0 = npulse;
      fire(3);
      wait_done();
      trig = 1'b1;
      step();
      trig = 1'b0;
      check("b2b_rise", int'(dtc_out), 1);
      wait_done();
      check("b2b_width", last_w, 3);
      check("b2b_gap", last_gap, 1);
      check("b2b_count", npulse - n0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dtc.md
Name: dtc

Overview:
- Digital-to-time converter: converts an unsigned digital code into a single output pulse whose width is that many clock periods.
- A trigger captures the code on `dtc_in`; `dtc_out` is then held high for exactly `dtc_in` cycles.
- Sits between a digital code source (controller/register) and timing-sensitive downstream logic that needs a programmable delay or pulse width.

Parameters:
- WIDTH, 8, bit width of the input code and the internal down-counter; maximum pulse is 2^WIDTH-1 cycles.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0); one clock; reset is asynchronous and active-low.
- dtc_in  input  WIDTH  unsigned pulse-width code, in clock cycles; sampled only on an accepted trigger.
- trig  input  1  start request; synchronous to clk; rising edge detected internally.
- dtc_out  output  1  registered pulse output; high for exactly dtc_in cycles per accepted trigger.

Behaviour:
- State: FSM states IDLE and BUSY; WIDTH-bit down-counter `cnt`; 1-bit register `trig_q` (trig delayed one cycle); `dtc_out` driven from a flop.
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, trig_q=0, dtc_out=0 immediately, independent of clk.
  - Deassertion takes effect at the next rising edge.
- Trigger detect: start_evt = trig & ~trig_q, evaluated at the rising edge; trig_q <= trig every cycle.
  - trig held high for several cycles yields one event only.
  - trig already high in the first cycle after reset release counts as an event.
- IDLE, start_evt, dtc_in != 0:
  - cnt <= dtc_in, dtc_out <= 1, state <= BUSY.
  - dtc_out rises at the same edge that samples trig (0 cycles latency after the sampling edge).
- IDLE, start_evt, dtc_in == 0: no pulse; dtc_out stays 0; remain IDLE.
- BUSY, each rising edge:
  - cnt <= cnt-1.
  - When cnt==1 at the edge: dtc_out <= 0, state <= IDLE.
  - dtc_out is therefore high for exactly N rising-edge-to-rising-edge periods, N = captured code.
- BUSY, start_evt: ignored. No retrigger or extension; `dtc_in` changes ignored (code latched at start).
- A start_evt in the first IDLE cycle after a pulse ends is accepted normally. Minimum gap between pulses is 1 cycle.
- Reset mid-pulse: dtc_out drops to 0 asynchronously, counter cleared, pulse aborted. No resume after reset release.
- Width rules:
  - Counter never wraps: it loads from dtc_in only in IDLE and stops at 1→IDLE.
  - Code 2^WIDTH-1 (255 at default) gives a 255-cycle pulse.
- No combinational path from inputs to dtc_out.

Test Plan:
- Reset then idle: rst=0 for 1 cycle, release, trig=0 -> dtc_out=0 throughout, no spurious pulse.
- dtc_in=5, trig high 1 cycle -> dtc_out high exactly 5 clk periods starting at the trig-sampling edge, then 0. Repeat with dtc_in=50 -> 50 cycles; dtc_in=255 -> 255 cycles.
- Boundary codes:
  - dtc_in=1 -> 1-cycle pulse.
  - dtc_in=0 with trig -> dtc_out stays 0 for 10+ cycles, FSM remains IDLE; next trig with dtc_in=3 -> 3-cycle pulse.
- Trig while busy and held trig:
  - dtc_in=20, trig; at cycle 5 change dtc_in=2 and pulse trig again -> pulse still exactly 20 cycles.
  - trig held high 30 cycles with dtc_in=4 -> exactly one 4-cycle pulse.
- Reset mid-operation: dtc_in=100, trig, after 10 cycles assert rst=0 between clock edges -> dtc_out falls immediately (before next edge). After release with trig=0 -> stays 0; new trig with dtc_in=7 -> 7-cycle pulse.
- Back-to-back: dtc_in=3 pulse; trig again in the first cycle after dtc_out falls -> second 3-cycle pulse with exactly 1 low cycle between.
